// File: rtl/pair_generator_pkg.sv
// pairgen_pkg: shared types and constants for the pair generator
// Holds the FSM encoding, slot/index sizing and the LFSR constants plus the
// one-step LFSR update used by lfsr16.
package pairgen_pkg;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam int          NUM_SLOTS    = 6;
    localparam int          IDX_W        = 4;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Galois right-shift step; never maps a non-zero state to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/pair_generator_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR
// Ports: clk (rising edge), rst (async, active-low),
//        o_state (current 16-bit register value).
// A zero SEED would lock the register at zero, so it is replaced by 1.
module lfsr16
    import pairgen_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] o_state
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= SEED_EFF;
        else
            r_state <= lfsr_next(r_state);
    end

    assign o_state = r_state;

endmodule

// File: rtl/pair_generator.sv
// pair_generator: draws six distinct 4-bit LED indices for the memory game
// Ports: clk (rising edge), rst (async, active-low), enable (start, IDLE only),
//        A..F (index slots 0..5; pairs A/F, B/E, C/D), endPairs (one-cycle
//        pulse, A..F new), busy (high in DRAW and DONE).
// Option: define PAIRGEN_FIXED_PATTERN_EN to skip DRAW and emit 0..5.
module pair_generator
    import pairgen_pkg::*;
#(
    parameter logic [15:0] SEED      = DEFAULT_SEED,
    parameter int          RETRY_MAX = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [IDX_W-1:0] A,
    output logic [IDX_W-1:0] B,
    output logic [IDX_W-1:0] C,
    output logic [IDX_W-1:0] D,
    output logic [IDX_W-1:0] E,
    output logic [IDX_W-1:0] F,
    output logic             endPairs,
    output logic             busy
);

    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    state_t           r_state, w_next;
    logic [15:0]      w_lfsr;
    logic [15:0]      r_used;
    logic [2:0]       r_slot;
    logic [RW-1:0]    r_retry;
    logic [IDX_W-1:0] r_shadow [NUM_SLOTS];
    logic [IDX_W-1:0] r_out    [NUM_SLOTS];
    logic [IDX_W-1:0] w_cand, w_low, w_pick;
    logic             w_start, w_fresh, w_store, w_last, w_unused;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .o_state (w_lfsr)
    );

    assign w_cand   = w_lfsr[IDX_W-1:0];
    assign w_unused = ^w_lfsr[15:IDX_W];
    assign w_start  = (r_state == IDLE) && enable;
    assign w_fresh  = !r_used[w_cand];
    // A slot is filled either by a fresh candidate or, once the retry budget
    // is spent, by the lowest free index.
    assign w_store  = (r_state == DRAW) && (w_fresh || (r_retry == RW'(RETRY_MAX)));
    assign w_pick   = w_fresh ? w_cand : w_low;
    assign w_last   = w_store && (r_slot == 3'(NUM_SLOTS - 1));

    // Lowest free index; at most five bits are set, so one is always free.
    always_comb begin
        w_low = '0;
        for (int i = 2**IDX_W - 1; i >= 0; i--)
            if (!r_used[i]) w_low = IDX_W'(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
`ifdef PAIRGEN_FIXED_PATTERN_EN
        w_next = (r_state == IDLE) ? (enable ? DONE : IDLE) : IDLE;
`else
        w_next = (r_state == IDLE) ? (enable ? DRAW : IDLE) :
                 (r_state == DRAW) ? (w_last ? DONE : DRAW) : IDLE;
`endif
    end

    always_comb begin
        busy     = (r_state != IDLE);
        endPairs = (r_state == DONE);
    end

    // Outputs load on the edge into DONE so they are new during the pulse;
    // slot 5 comes straight from the pick since its shadow is written then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_used  <= '0;
            r_slot  <= '0;
            r_retry <= '0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                r_shadow[k] <= '0;
                r_out[k]    <= '0;
            end
        end else if (w_start) begin
            r_used  <= '0;
            r_slot  <= '0;
            r_retry <= '0;
`ifdef PAIRGEN_FIXED_PATTERN_EN
            for (int k = 0; k < NUM_SLOTS; k++)
                r_out[k] <= IDX_W'(k);
`endif
        end else if (w_store) begin
            r_shadow[r_slot] <= w_pick;
            r_used[w_pick]   <= 1'b1;
            r_retry          <= '0;
            r_slot           <= r_slot + 3'd1;
            if (w_last)
                for (int k = 0; k < NUM_SLOTS; k++)
                    r_out[k] <= (k == NUM_SLOTS - 1) ? w_pick : r_shadow[k];
        end else if (r_state == DRAW) begin
            r_retry <= r_retry + RW'(1);
        end
    end

    assign A = r_out[0];
    assign B = r_out[1];
    assign C = r_out[2];
    assign D = r_out[3];
    assign E = r_out[4];
    assign F = r_out[5];

endmodule

// File: tb/tb_pair_generator.sv
// tb_pair_generator: checks two pair_generator instances against a draw model
// u0 uses the default parameters; u1 uses SEED=0 (zero guard) and RETRY_MAX=0
// so every duplicate falls back to the lowest free index.
module tb_pair_generator;

    localparam logic [15:0] SD0 = 16'hACE1;
    localparam logic [15:0] SD1 = 16'h0000;
`ifdef PAIRGEN_FIXED_PATTERN_EN
    localparam int          PIN_N = 1;
    localparam logic [23:0] PIN0  = 24'h543210;
`else
    localparam int          PIN_N = 7;
    localparam logic [23:0] PIN0  = 24'h37EC80;
`endif
    localparam logic [23:0] PIN1 = 24'h543210;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic [3:0] a0, b0, c0, d0, e0, f0, a1, b1, c1, d1, e1, f1;
    logic [23:0] d_out [2];
    logic d_end [2];
    logic d_busy [2];

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr [2];
    int          m_cnt  [2];
    logic        m_end  [2];
    logic [23:0] m_out  [2];
    logic [23:0] m_res  [2];

    always #5 clk = ~clk;

    pair_generator u0 (
        .clk(clk), .rst(rst), .enable(enable),
        .A(a0), .B(b0), .C(c0), .D(d0), .E(e0), .F(f0),
        .endPairs(d_end[0]), .busy(d_busy[0])
    );

    pair_generator #(.SEED(SD1), .RETRY_MAX(0)) u1 (
        .clk(clk), .rst(rst), .enable(enable),
        .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .F(f1),
        .endPairs(d_end[1]), .busy(d_busy[1])
    );

    assign d_out[0] = {f0, e0, d0, c0, b0, a0};
    assign d_out[1] = {f1, e1, d1, c1, b1, a1};

    function automatic logic [15:0] nxt(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] seed_of(input int u);
        logic [15:0] s;
        s = (u == 0) ? SD0 : SD1;
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    function automatic int rmax_of(input int u);
        return (u == 0) ? 7 : 0;
    endfunction

    // Whole draw starting from the LFSR value seen at the start edge:
    // returns {cycles spent in DRAW, F..A packed low slot first}.
    function automatic logic [31:0] draw(input logic [15:0] l0, input int rmax);
`ifdef PAIRGEN_FIXED_PATTERN_EN
        return {8'd0, 24'h543210};
`else
        logic [15:0] l, used;
        logic [23:0] res;
        logic [3:0]  pick;
        int          n, r;
        bit          got;
        l = nxt(l0);
        used = '0;
        res = '0;
        pick = '0;
        n = 0;
        for (int s = 0; s < 6; s++) begin
            r = 0;
            got = 0;
            while (!got) begin
                n++;
                if (!used[l[3:0]]) begin
                    pick = l[3:0];
                    got = 1;
                end else if (r == rmax) begin
                    for (int i = 15; i >= 0; i--)
                        if (!used[i]) pick = 4'(i);
                    got = 1;
                end else begin
                    r++;
                end
                l = nxt(l);
            end
            used[pick] = 1'b1;
            res[s*4 +: 4] = pick;
        end
        return {8'(n), res};
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst) begin
                m_lfsr[u] <= seed_of(u);
                m_cnt[u]  <= 0;
                m_end[u]  <= 1'b0;
                m_out[u]  <= '0;
                m_res[u]  <= '0;
            end else begin
                m_lfsr[u] <= nxt(m_lfsr[u]);
                if (m_end[u]) begin
                    m_end[u] <= 1'b0;
                end else if (m_cnt[u] != 0) begin
                    m_cnt[u] <= m_cnt[u] - 1;
                    if (m_cnt[u] == 1) begin
                        m_end[u] <= 1'b1;
                        m_out[u] <= m_res[u];
                    end
                end else if (enable) begin
                    m_res[u] <= 24'(draw(m_lfsr[u], rmax_of(u)));
                    if (8'(draw(m_lfsr[u], rmax_of(u)) >> 24) == 8'd0) begin
                        m_end[u] <= 1'b1;
                        m_out[u] <= 24'(draw(m_lfsr[u], rmax_of(u)));
                    end else begin
                        m_cnt[u] <= int'(8'(draw(m_lfsr[u], rmax_of(u)) >> 24));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            int dup;
            chk($sformatf("u%0d endPairs", u), 32'(d_end[u]), 32'(m_end[u]));
            chk($sformatf("u%0d busy", u), 32'(d_busy[u]), 32'((m_cnt[u] != 0) || m_end[u]));
            chk($sformatf("u%0d A..F", u), 32'(d_out[u]), 32'(m_out[u]));
            if (d_end[u]) begin
                dup = 0;
                for (int i = 0; i < 6; i++)
                    for (int j = i + 1; j < 6; j++)
                        if (d_out[u][i*4 +: 4] == d_out[u][j*4 +: 4]) dup++;
                chk($sformatf("u%0d distinct", u), 32'(dup), 32'd0);
            end
        end
    end

    task automatic pin_first();
        rst = 1'b1;
        repeat (PIN_N) @(negedge clk);
        chk("u0 first end", 32'(d_end[0]), 32'd1);
        chk("u1 first end", 32'(d_end[1]), 32'd1);
        chk("u0 first A..F", 32'(d_out[0]), 32'(PIN0));
        chk("u1 first A..F", 32'(d_out[1]), 32'(PIN1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (d_busy[0] || d_busy[1]); i++) @(negedge clk);
        chk("idle timeout", 32'(d_busy[0] | d_busy[1]), 32'd0);
    endtask

    task automatic count_ends(input int cyc, output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            n0 += int'(d_end[0]);
            n1 += int'(d_end[1]);
        end
    endtask

    initial begin
        int n0, n1, n;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        pin_first();
`ifndef PAIRGEN_FIXED_PATTERN_EN
        repeat (8) @(negedge clk);
        chk("u1 second end", 32'(d_end[1]), 32'd1);
        chk("u1 second A..F", 32'(d_out[1]), 32'h5B6DA4);
`endif
        enable = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        count_ends(60, n0, n1);
        chk("u0 single pulse count", 32'(n0), 32'd1);
        chk("u1 single pulse count", 32'(n1), 32'd1);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        count_ends(60, n0, n1);
`ifndef PAIRGEN_FIXED_PATTERN_EN
        chk("u0 busy-enable count", 32'(n0), 32'd1);
        chk("u1 busy-enable count", 32'(n1), 32'd1);
`endif
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_idle();
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 60000 && n < 1000; i++) begin
            @(negedge clk);
            n += int'(d_end[0]);
        end
        chk("back-to-back rounds", 32'(n), 32'd1000);
        enable = 1'b0;
        wait_idle();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("u0 async A..F", 32'(d_out[0]), 32'd0);
        chk("u1 async A..F", 32'(d_out[1]), 32'd0);
        chk("u0 async endPairs", 32'(d_end[0]), 32'd0);
        chk("u1 async endPairs", 32'(d_end[1]), 32'd0);
        chk("u0 async busy", 32'(d_busy[0]), 32'd0);
        chk("u1 async busy", 32'(d_busy[1]), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        pin_first();
        enable = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
